// File: rtl/sdram_bus_arbiter.sv
// Two-port (I/D) arbiter in front of a single SDRAM controller bus; registers the granted request.
// Optional ARB_ROUND_ROBIN_EN: alternate ownership on contention instead of fixed D-over-I priority.
module sdram_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_we,
  input  logic              i_start,
  output logic [DATA_W-1:0] i_q,
  output logic              i_done,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_we,
  input  logic              d_start,
  output logic [DATA_W-1:0] d_q,
  output logic              d_done,
  output logic [ADDR_W-1:0] sdc_addr,
  output logic [DATA_W-1:0] sdc_data,
  output logic              sdc_we,
  output logic              sdc_start,
  input  logic [DATA_W-1:0] sdc_q,
  input  logic              sdc_done,
  output logic [1:0]        arb_grant
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_sdc_addr, w_sdc_addr;
  logic [DATA_W-1:0] r_sdc_data, w_sdc_data;
  logic              r_sdc_we, w_sdc_we;
  logic              r_sdc_start, w_sdc_start;
  logic [DATA_W-1:0] r_i_q, w_i_q;
  logic [DATA_W-1:0] r_d_q, w_d_q;
  logic              r_i_done, w_i_done;
  logic              r_d_done, w_d_done;
  logic [1:0]        r_grant, w_grant;
  logic              w_pick_d;
  logic              w_any_start;

  assign w_any_start = i_start | d_start;

`ifdef ARB_ROUND_ROBIN_EN
  // Last owner: 1 = port D. Reset to D so the first contended grant goes to I.
  logic r_last_d;

  assign w_pick_d = d_start & (~i_start | ~r_last_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d <= 1'b1;
    end else if (r_state == ST_IDLE && w_any_start) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = d_start;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sdc_addr  <= '0;
      r_sdc_data  <= '0;
      r_sdc_we    <= 1'b0;
      r_sdc_start <= 1'b0;
      r_i_q       <= '0;
      r_d_q       <= '0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_grant     <= GNT_NONE;
    end else begin
      r_state     <= w_state;
      r_sdc_addr  <= w_sdc_addr;
      r_sdc_data  <= w_sdc_data;
      r_sdc_we    <= w_sdc_we;
      r_sdc_start <= w_sdc_start;
      r_i_q       <= w_i_q;
      r_d_q       <= w_d_q;
      r_i_done    <= w_i_done;
      r_d_done    <= w_d_done;
      r_grant     <= w_grant;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_sdc_addr  = r_sdc_addr;
    w_sdc_data  = r_sdc_data;
    w_sdc_we    = r_sdc_we;
    w_sdc_start = r_sdc_start;
    w_i_q       = r_i_q;
    w_d_q       = r_d_q;
    w_i_done    = 1'b0;
    w_d_done    = 1'b0;
    w_grant     = r_grant;

    case (r_state)
      ST_IDLE: begin
        if (w_any_start) begin
          w_state     = ST_BUSY;
          w_sdc_start = 1'b1;
          if (w_pick_d) begin
            w_sdc_addr = d_addr;
            w_sdc_data = d_data;
            w_sdc_we   = d_we;
            w_grant    = GNT_D;
          end else begin
            w_sdc_addr = i_addr;
            w_sdc_data = i_data;
            w_sdc_we   = i_we;
            w_grant    = GNT_I;
          end
        end
      end
      ST_BUSY: begin
        // Requester inputs are ignored here; only the controller's completion matters.
        if (sdc_done) begin
          if (r_grant == GNT_D) begin
            w_d_q    = sdc_q;
            w_d_done = 1'b1;
          end else begin
            w_i_q    = sdc_q;
            w_i_done = 1'b1;
          end
          w_sdc_start = 1'b0;
          w_grant     = GNT_NONE;
          w_state     = ST_RELEASE;
        end
      end
      ST_RELEASE: w_state = ST_IDLE;
      default:    w_state = ST_IDLE;
    endcase
  end

  assign sdc_addr  = r_sdc_addr;
  assign sdc_data  = r_sdc_data;
  assign sdc_we    = r_sdc_we;
  assign sdc_start = r_sdc_start;
  assign i_q       = r_i_q;
  assign d_q       = r_d_q;
  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign arb_grant = r_grant;

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed self-checking bench for sdram_bus_arbiter; inputs driven and outputs sampled 1ns after posedge.
module tb_sdram_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] i_addr, d_addr, sdc_addr;
  logic [DATA_W-1:0] i_data, d_data, sdc_data;
  logic              i_we, d_we, sdc_we;
  logic              i_start, d_start, sdc_start;
  logic [DATA_W-1:0] i_q, d_q, sdc_q;
  logic              i_done, d_done, sdc_done;
  logic [1:0]        arb_grant;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sdram_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_addr(i_addr), .i_data(i_data), .i_we(i_we), .i_start(i_start), .i_q(i_q), .i_done(i_done),
    .d_addr(d_addr), .d_data(d_data), .d_we(d_we), .d_start(d_start), .d_q(d_q), .d_done(d_done),
    .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
    .sdc_q(sdc_q), .sdc_done(sdc_done), .arb_grant(arb_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 0; d_start = 0; i_we = 0; d_we = 0; sdc_done = 0;
    i_addr = '0; d_addr = '0; i_data = '0; d_data = '0; sdc_q = '0;
    tick(); tick();
    checks++; if (sdc_start !== 1'b0) $display("FAIL reset_sdc_start got %b want 0", sdc_start); else passed++;
    checks++; if (sdc_we !== 1'b0) $display("FAIL reset_sdc_we got %b want 0", sdc_we); else passed++;
    checks++; if (arb_grant !== 2'b00) $display("FAIL reset_grant got %b want 00", arb_grant); else passed++;
    checks++; if ({i_done, d_done} !== 2'b00) $display("FAIL reset_done got %b want 00", {i_done, d_done}); else passed++;
    checks++; if ({sdc_addr, sdc_data, i_q, d_q} !== 128'h0) $display("FAIL reset_data got %h want 0", {sdc_addr, sdc_data, i_q, d_q}); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_i();
    i_start = 1; i_addr = 32'h0000_0100; i_we = 0; i_data = 32'h5555_5555;
    tick();
    checks++; if (sdc_start !== 1'b1) $display("FAIL rdi_sdc_start got %b want 1", sdc_start); else passed++;
    checks++; if (sdc_addr !== 32'h100) $display("FAIL rdi_sdc_addr got %h want 00000100", sdc_addr); else passed++;
    checks++; if (arb_grant !== 2'b01) $display("FAIL rdi_grant got %b want 01", arb_grant); else passed++;
    checks++; if (sdc_we !== 1'b0) $display("FAIL rdi_sdc_we got %b want 0", sdc_we); else passed++;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if ({i_done, d_done, sdc_start} !== 3'b001) $display("FAIL rdi_wait%0d got %b want 001", k, {i_done, d_done, sdc_start}); else passed++;
    end
    sdc_done = 1; sdc_q = 32'hDEAD_BEEF;
    tick();
    sdc_done = 0; i_start = 0;
    checks++; if (i_done !== 1'b1) $display("FAIL rdi_done got %b want 1", i_done); else passed++;
    checks++; if (i_q !== 32'hDEAD_BEEF) $display("FAIL rdi_q got %h want deadbeef", i_q); else passed++;
    checks++; if (d_done !== 1'b0) $display("FAIL rdi_d_done got %b want 0", d_done); else passed++;
    checks++; if ({sdc_start, arb_grant} !== 3'b000) $display("FAIL rdi_release got %b want 000", {sdc_start, arb_grant}); else passed++;
    tick();
    checks++; if (i_done !== 1'b0) $display("FAIL rdi_done_pulse got %b want 0", i_done); else passed++;
    tick();
  endtask

  task automatic test_write_d();
    d_start = 1; d_addr = 32'h0000_0200; d_data = 32'h1234_5678; d_we = 1;
    tick();
    d_data = 32'hFFFF_0000; d_we = 0;
    checks++; if (arb_grant !== 2'b10) $display("FAIL wrd_grant got %b want 10", arb_grant); else passed++;
    checks++; if (sdc_addr !== 32'h200) $display("FAIL wrd_addr got %h want 00000200", sdc_addr); else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({sdc_we, sdc_data} !== {1'b1, 32'h1234_5678}) $display("FAIL wrd_hold%0d got %b/%h want 1/12345678", k, sdc_we, sdc_data); else passed++;
    end
    sdc_done = 1; sdc_q = 32'hCAFE_F00D;
    tick();
    sdc_done = 0; d_start = 0;
    checks++; if ({i_done, d_done} !== 2'b01) $display("FAIL wrd_done got %b want 01", {i_done, d_done}); else passed++;
    checks++; if (d_q !== 32'hCAFE_F00D) $display("FAIL wrd_q got %h want cafef00d", d_q); else passed++;
    checks++; if (i_q !== 32'hDEAD_BEEF) $display("FAIL wrd_iq_kept got %h want deadbeef", i_q); else passed++;
    tick(); tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_addr = 32'h300; d_addr = 32'h400; i_we = 0; d_we = 0;
`ifdef ARB_ROUND_ROBIN_EN
    begin
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      i_start = 1; d_start = 1;
      for (int n = 0; n < 4; n++) begin
        tick();
        checks++; if (arb_grant !== exp_g[n]) $display("FAIL rr_grant%0d got %b want %b", n, arb_grant, exp_g[n]); else passed++;
        tick();
        sdc_done = 1; sdc_q = 32'(n);
        tick();
        sdc_done = 0;
        tick();
      end
      i_start = 0; d_start = 0;
      tick(); tick();
    end
`else
    i_start = 1; d_start = 1;
    tick();
    checks++; if (arb_grant !== 2'b10) $display("FAIL sim_first got %b want 10", arb_grant); else passed++;
    checks++; if (sdc_addr !== 32'h400) $display("FAIL sim_first_addr got %h want 00000400", sdc_addr); else passed++;
    tick(); tick();
    sdc_done = 1; sdc_q = 32'h1111_1111;
    tick();
    sdc_done = 0; d_start = 0;
    checks++; if ({d_done, d_q} !== {1'b1, 32'h1111_1111}) $display("FAIL sim_d_done got %b/%h want 1/11111111", d_done, d_q); else passed++;
    tick();
    checks++; if ({sdc_start, arb_grant} !== 3'b000) $display("FAIL sim_gap got %b want 000", {sdc_start, arb_grant}); else passed++;
    tick();
    checks++; if ({sdc_start, arb_grant, sdc_addr} !== {3'b101, 32'h300}) $display("FAIL sim_second got %b/%h want 101/00000300", {sdc_start, arb_grant}, sdc_addr); else passed++;
    tick();
    sdc_done = 1; sdc_q = 32'h2222_2222;
    tick();
    sdc_done = 0; i_start = 0;
    checks++; if ({i_done, d_done, i_q} !== {2'b10, 32'h2222_2222}) $display("FAIL sim_i_done got %b/%h want 10/22222222", {i_done, d_done}, i_q); else passed++;
    tick(); tick();
`endif
  endtask

  task automatic test_stable_busy();
    i_start = 1; i_addr = 32'h10; i_we = 0;
    tick();
    i_addr = 32'h20;
    checks++; if (sdc_addr !== 32'h10) $display("FAIL stab_init got %h want 00000010", sdc_addr); else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({sdc_addr, arb_grant} !== {32'h10, 2'b01}) $display("FAIL stab_hold%0d got %h/%b want 00000010/01", k, sdc_addr, arb_grant); else passed++;
    end
    sdc_done = 1; sdc_q = 32'h3030_3030;
    tick();
    sdc_done = 0; i_start = 0;
    checks++; if (i_done !== 1'b1) $display("FAIL stab_done got %b want 1", i_done); else passed++;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    i_start = 1; i_addr = 32'h50;
    tick();
    checks++; if (arb_grant !== 2'b01) $display("FAIL rstm_grant got %b want 01", arb_grant); else passed++;
    reset = 1;
    tick();
    reset = 0; i_start = 0;
    checks++; if ({sdc_start, arb_grant, i_done, d_done} !== 5'b0) $display("FAIL rstm_state got %b want 00000", {sdc_start, arb_grant, i_done, d_done}); else passed++;
    tick();
    checks++; if ({i_done, d_done, sdc_start} !== 3'b000) $display("FAIL rstm_nodone got %b want 000", {i_done, d_done, sdc_start}); else passed++;
    d_start = 1; d_addr = 32'h60;
    tick();
    checks++; if ({arb_grant, sdc_addr} !== {2'b10, 32'h60}) $display("FAIL rstm_idle_grant got %b/%h want 10/00000060", arb_grant, sdc_addr); else passed++;
    sdc_done = 1; sdc_q = 32'h3333_3333;
    tick();
    sdc_done = 0; d_start = 0;
    checks++; if ({d_done, d_q} !== {1'b1, 32'h3333_3333}) $display("FAIL rstm_d_done got %b/%h want 1/33333333", d_done, d_q); else passed++;
    // Controller repeats done during RELEASE: must be ignored
    sdc_done = 1; sdc_q = 32'hBAD0_BAD0;
    tick();
    sdc_done = 0;
    checks++; if ({i_done, d_done, d_q} !== {2'b00, 32'h3333_3333}) $display("FAIL spur_release got %b/%h want 00/33333333", {i_done, d_done}, d_q); else passed++;
    tick();
  endtask

  task automatic test_spurious();
    sdc_done = 1; sdc_q = 32'hBAD0_BAD0;
    tick();
    tick();
    sdc_done = 0;
    checks++; if ({i_done, d_done, sdc_start} !== 3'b000) $display("FAIL spur_idle_done got %b want 000", {i_done, d_done, sdc_start}); else passed++;
    checks++; if ({i_q, d_q} !== {32'h0, 32'h3333_3333}) $display("FAIL spur_idle_q got %h/%h want 00000000/33333333", i_q, d_q); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_i();
    test_write_d();
    test_simultaneous();
    test_stable_busy();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
